lsu: RTL and testbench
======================

# lsu

Load/store unit for the single-cycle core's MEM stage. It takes the decoded load/store request (effective address, store data, funct3), runs one transaction on a word-wide data-memory bus with a req/gnt/rvalid handshake, and aligns and sign-extends load data. It returns a one-cycle response for register writeback. While a transaction is outstanding it holds the core's `stall` input high so the PC and the instruction do not change.

## Interface
- `MAX_WAIT`, default 255: cycles spent in ADDR+DATA before the access is aborted with an error (1..65535).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  current instruction is a load or store; held stable by the core while `stall`=1.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width/sign code: LB/LH/LW/LBU/LHU, SB/SH/SW.
- `req_addr`  in  32  effective byte address (rs1 + imm).
- `req_wdata`  in  32  store data (rs2).
- `stall`  out  1  freeze the core; combinational.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  extended load result; 0 unless `rsp_valid` is high on a successful load.
- `rsp_err`  out  1  misaligned access, illegal funct3 or timeout; qualified by `rsp_valid`.
- `mem_req`  out  1  bus request; held until `mem_gnt`.
- `mem_we`  out  1  bus write.
- `mem_addr`  out  32  word address `{addr[31:2],2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_gnt`  in  1  request accepted.
- `mem_rvalid`  in  1  read data valid, or write acknowledge.
- `mem_rdata`  in  32  read word.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- **IDLE**
  - Outputs are idle. On `req_valid`, the request is registered (we, funct3, addr[1:0], be, wdata, word address).
  - Legal request: go to ADDR.
  - Misaligned or illegal request: go to DONE with error set and no bus activity.
- **ADDR**
  - `mem_req`=1 with registered address/we/be/wdata, stable until `mem_gnt`.
  - On `mem_gnt`: go to DATA.
- **DATA**
  - On `mem_rvalid`: capture the aligned result and go to DONE.
  - `mem_rvalid` is ignored in every other state, including late responses after a timeout.
- **DONE**
  - `rsp_valid`=1 for exactly one cycle, then IDLE.
  - IDLE does not sample `req_valid` during DONE: the core still presents the same instruction in that cycle.
- `stall` = `rst` & `req_valid` & !(state==DONE).
- **Timeout:** a counter clears on entry to ADDR and increments every cycle in ADDR/DATA. When it reaches `MAX_WAIT`: drop `mem_req`, go to DONE with `rsp_err`=1 and `rsp_rdata`=0.
- **Byte enables:**
  - Byte: `mem_be` = 4'b0001 << addr[1:0].
  - Half: `mem_be` = 4'b0011 << addr[1:0].
  - Word: `mem_be` = 4'b1111.
  - Loads drive the same `mem_be` pattern.
- **Store data:** SB `{4{wdata[7:0]}}`; SH `{2{wdata[15:0]}}`; SW `wdata`.
- **Load extraction:** take the byte or half at offset addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **Misaligned:** half with addr[0]=1; word with addr[1:0]≠0.
- **Illegal funct3:** loads 3'b011, 3'b110, 3'b111; stores ≥ 3'b011.
- Stores and error responses return `rsp_rdata`=0.

## Timing
- **Reset values (immediate, asynchronous):** state IDLE, counter 0, every output 0 (including `stall`).
- **Reset mid-transaction:** the request is abandoned and `mem_req` drops the same instant.
- **Best case (gnt in the ADDR cycle, rvalid in the first DATA cycle):**
  - c0: IDLE, stall=1.
  - c1: ADDR, mem_req=1.
  - c2: DATA.
  - c3: DONE, rsp_valid=1, stall=0.
  - The instruction occupies 4 cycles.
- **Error path:** c0 IDLE → c1 DONE with err, so the instruction occupies 2 cycles.
- **Bus timing:**
  - `mem_gnt` is sampled only in ADDR.
  - `mem_rvalid` is never accepted in the same cycle as `mem_gnt`.
  - Each wait cycle adds one cycle of latency.
- **Back-to-back:** a second load/store presented the cycle after DONE is sampled in IDLE normally, with no bubble beyond IDLE.

## Structure
- Shared `def` package holds:
  - the `lsu_state_t` enum;
  - funct3 constants `F3_LB`..`F3_LHU` and `F3_SB`..`F3_SW`;
  - the `MAX_WAIT` default.
- Sub-module `lsu_align` (combinational):
  - inputs funct3 and addr[1:0];
  - outputs `be`, replicated wdata, misaligned/illegal flags, and the extended load value from the raw word.
  - It is reused by the FSM at capture and at load return.
- The FSM, timeout counter and registers live in `lsu` itself (≈200 lines total).

## Test plan
- **Load byte, signed:** LB, addr 0x1003, mem_rdata 0x80AA_BBCC, gnt and rvalid immediate → mem_addr 0x1000, mem_be 4'b1000, rsp_rdata 0xFFFF_FF80, rsp_valid in c3, stall high c0–c2.
- **Store half:** SH, addr 0x2002, wdata 0x1234_5678 → mem_we=1, mem_be 4'b1100, mem_wdata 0x5678_5678; rsp_rdata=0 and rsp_err=0 on rvalid ack.
- **Misaligned word:** LW at 0x0001 → no mem_req ever, rsp_valid and rsp_err in c1. SB with funct3 3'b101 → same response.
- **Wait states:** gnt delayed 3 cycles, rvalid delayed 2 → mem_req stable 4 cycles, rsp_valid exactly one cycle, LHU of 0xFFFF at offset 2 returns 0x0000_FFFF.
- **Timeout:** `MAX_WAIT`=8, gnt never → mem_req drops after 8 cycles, rsp_err=1; a late rvalid in IDLE is ignored.
- **Reset mid-op:** rst low during DATA → all outputs 0 immediately. After release with req_valid=1, a fresh transaction starts from IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM state type, RV32I load/store funct3 codes and the default timeout
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int unsigned MAX_WAIT_DEF = 255;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic (enables, store replication, load extract, request checks)
//   in : we, funct3, off (addr[1:0]), wdata (raw store data), rdata (raw bus word)
//   out: be, wdata_rep, misaligned, illegal, rdata_ext (aligned, extended load value)
module lsu_align import lsu_pkg::*; (
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misaligned,
    output logic        illegal,
    output logic [31:0] rdata_ext
);

    logic [1:0]  size;
    logic [31:0] sh;

    // funct3[1:0] encodes the access width for both loads and stores
    assign size       = funct3[1:0];
    assign be         = size == 2'd0 ? 4'b0001 << off : size == 2'd1 ? 4'b0011 << off : 4'b1111;
    assign wdata_rep  = size == 2'd0 ? {4{wdata[7:0]}} : size == 2'd1 ? {2{wdata[15:0]}} : wdata;
    assign misaligned = (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
    assign illegal    = we ? funct3 > F3_SW : (size == 2'd3 || funct3 == 3'b110);
    assign sh         = rdata >> {off, 3'b000};
    assign rdata_ext  = funct3 == F3_LB  ? {{24{sh[7]}}, sh[7:0]} :
                        funct3 == F3_LH  ? {{16{sh[15]}}, sh[15:0]} :
                        funct3 == F3_LBU ? {24'd0, sh[7:0]} :
                        funct3 == F3_LHU ? {16'd0, sh[15:0]} : sh;

endmodule

// File: rtl/lsu.sv
// lsu: MEM-stage load/store unit running one req/gnt/rvalid bus transaction per instruction
//   core side: req_valid/req_we/req_funct3/req_addr/req_wdata in; stall, rsp_valid/rsp_rdata/rsp_err out
//   bus side : mem_req/mem_we/mem_addr/mem_be/mem_wdata out; mem_gnt/mem_rvalid/mem_rdata in
//   rst is asynchronous and active-low; MAX_WAIT bounds the cycles spent in ADDR+DATA
module lsu import lsu_pkg::*; #(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [15:0] LAST = 16'(MAX_WAIT - 1);

    lsu_state_t  state, nxt;
    logic        we_q, err_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [3:0]  be_q, be;
    logic [29:0] addr_q;
    logic [31:0] wdata_q, rdata_q, wdata_rep, rdata_ext;
    logic [15:0] cnt;
    logic        idle, busy, tmo, misaligned, illegal;

    assign idle = state == IDLE;
    assign busy = state == ADDR || state == DATA;
    assign tmo  = busy && cnt == LAST;

    // One aligner serves both request capture (live inputs) and load return (registered request)
    lsu_align u_align (
        .we        (idle ? req_we : we_q),
        .funct3    (idle ? req_funct3 : f3_q),
        .off       (idle ? req_addr[1:0] : off_q),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .misaligned(misaligned),
        .illegal   (illegal),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // Timeout outranks a same-cycle grant; a same-cycle rvalid still completes the load
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !req_valid ? IDLE : (misaligned || illegal) ? DONE : ADDR;
            ADDR:    nxt = tmo ? DONE : mem_gnt ? DATA : ADDR;
            DATA:    nxt = (mem_rvalid || tmo) ? DONE : DATA;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            be_q    <= 4'd0;
            addr_q  <= 30'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt     <= 16'd0;
        end else begin
            cnt <= busy ? cnt + 16'd1 : 16'd0;
            if (idle && req_valid) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                off_q   <= req_addr[1:0];
                be_q    <= be;
                addr_q  <= req_addr[31:2];
                wdata_q <= wdata_rep;
                rdata_q <= 32'd0;
                err_q   <= misaligned || illegal;
            end else if (state == DATA && mem_rvalid) begin
                rdata_q <= we_q ? 32'd0 : rdata_ext;
                err_q   <= 1'b0;
            end else if (tmo) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b1;
            end
        end
    end

    // All outputs decode from state, so an asynchronous reset clears them at once
    assign stall     = rst && req_valid && state != DONE;
    assign rsp_valid = state == DONE;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign mem_req   = state == ADDR;
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? {addr_q, 2'b00} : 32'd0;
    assign mem_be    = mem_req ? be_q : 4'd0;
    assign mem_wdata = mem_req ? wdata_q : 32'd0;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu with a byte-level reference model and a scripted bus responder
module tb_lsu;
    import lsu_pkg::*;

    localparam int MW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        stall, rsp_valid, rsp_err, mem_req, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        int          reqn;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        bit          stable;
        logic [31:0] rdata;
        logic        err;
        bit          stall_ok;
        logic        extra;
    } obs_t;

    always #5 clk = ~clk;

    lsu #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Reference: access described as a set of byte lanes [off, off+size)
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  output logic err, output logic [3:0] be,
                                  output logic [31:0] mw, output logic [31:0] rv);
        int size, off;
        bit sgn, ok;
        off = int'(addr % 4);
        size = 4; sgn = 0; ok = 1;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: size = 4;
            3'd4: begin size = 1; ok = !we; end
            3'd5: begin size = 2; ok = !we; end
            default: ok = 0;
        endcase
        err = !ok || (off % size != 0);
        be = 4'd0; mw = 32'd0; rv = 32'd0;
        for (int i = 0; i < 4; i++) begin
            be[i] = (i >= off && i < off + size);
            mw[8*i +: 8] = wdata[8*(i % size) +: 8];
        end
        for (int j = 0; j < size; j++)
            if (off + j < 4) rv[8*j +: 8] = rdata[8*(off + j) +: 8];
        if (sgn && size < 4 && rv[8*size-1]) rv = rv | (32'hFFFF_FFFF << (8*size));
        if (we || err) rv = 32'd0;
    endfunction

    // Presents one request in IDLE, grants after gd request cycles, answers after rd data
    // cycles, and returns one cycle after the response (in IDLE, ready for the next request)
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int gd, input int rd, output obs_t o);
        bit granted, g, r;
        int dw;
        o = '{default: 0};
        o.stable = 1; o.stall_ok = 1;
        granted = 0; dw = 0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        mem_rdata = rdata;
        #1;
        while (o.cyc < 40) begin
            if (rsp_valid === 1'b1) break;
            if (stall !== 1'b1) o.stall_ok = 0;
            if (mem_req === 1'b1) begin
                if (o.reqn == 0) begin
                    o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata; o.we = mem_we;
                end else if ({mem_addr, mem_be, mem_wdata, mem_we} !== {o.addr, o.be, o.wdata, o.we}) o.stable = 0;
            end
            g = mem_req === 1'b1 && o.reqn == gd;
            r = granted && dw == rd;
            mem_gnt = g; mem_rvalid = r;
            if (mem_req === 1'b1) o.reqn++;
            if (granted) dw++;
            @(posedge clk); #1;
            if (g) granted = 1;
            o.cyc++;
        end
        o.rdata = rsp_rdata; o.err = rsp_err;
        if (stall !== 1'b0) o.stall_ok = 0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        o.extra = rsp_valid;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        req_valid = 1'b1; req_addr = 32'h0000_1000; req_funct3 = F3_LW;
        #2;
        n_checks++;
        if ({stall, rsp_valid, rsp_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_outputs stall=%b rsp_valid=%b mem_req=%b got nonzero, want all 0", stall, rsp_valid, mem_req);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({stall, rsp_valid, mem_req} !== 3'b000) begin
            n_fail++; $display("FAIL reset_held stall/rsp_valid/mem_req=%b want 000", {stall, rsp_valid, mem_req});
        end
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_byte;
        obs_t o;
        run_txn(1'b0, F3_LB, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 0, o);
        n_checks++;
        if (o.cyc !== 3) begin n_fail++; $display("FAIL lb_latency got %0d want 3", o.cyc); end
        n_checks++;
        if ({o.addr, o.be, o.we} !== {32'h0000_1000, 4'b1000, 1'b0}) begin
            n_fail++; $display("FAIL lb_bus addr=%h be=%b we=%b want 00001000 1000 0", o.addr, o.be, o.we);
        end
        n_checks++;
        if ({o.rdata, o.err} !== {32'hFFFF_FF80, 1'b0}) begin
            n_fail++; $display("FAIL lb_rdata got %h err=%b want ffffff80 err=0", o.rdata, o.err);
        end
        n_checks++;
        if ({o.stall_ok, o.extra} !== 2'b10) begin
            n_fail++; $display("FAIL lb_stall_pulse stall_ok=%b extra=%b want 1 0", o.stall_ok, o.extra);
        end
    endtask

    task automatic test_store_half;
        obs_t o;
        run_txn(1'b1, F3_SH, 32'h0000_2002, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0, o);
        n_checks++;
        if ({o.we, o.be, o.wdata, o.addr} !== {1'b1, 4'b1100, 32'h5678_5678, 32'h0000_2000}) begin
            n_fail++; $display("FAIL sh_bus we=%b be=%b wdata=%h addr=%h want 1 1100 56785678 00002000", o.we, o.be, o.wdata, o.addr);
        end
        n_checks++;
        if ({o.rdata, o.err, o.cyc} !== {32'd0, 1'b0, 32'd3}) begin
            n_fail++; $display("FAIL sh_rsp rdata=%h err=%b cyc=%0d want 0 0 3", o.rdata, o.err, o.cyc);
        end
    endtask

    task automatic test_misaligned;
        obs_t o;
        run_txn(1'b0, F3_LW, 32'h0000_0001, 32'h0, 32'hFFFF_FFFF, 0, 0, o);
        n_checks++;
        if ({o.cyc, o.reqn} !== {32'd1, 32'd0} || {o.err, o.rdata} !== {1'b1, 32'd0}) begin
            n_fail++; $display("FAIL misaligned_lw cyc=%0d reqn=%0d err=%b rdata=%h want 1 0 1 0", o.cyc, o.reqn, o.err, o.rdata);
        end
        run_txn(1'b1, 3'b101, 32'h0000_0010, 32'hAAAA_5555, 32'hFFFF_FFFF, 0, 0, o);
        n_checks++;
        if ({o.cyc, o.reqn} !== {32'd1, 32'd0} || {o.err, o.rdata, o.extra} !== {1'b1, 32'd0, 1'b0}) begin
            n_fail++; $display("FAIL illegal_store cyc=%0d reqn=%0d err=%b rdata=%h extra=%b want 1 0 1 0 0", o.cyc, o.reqn, o.err, o.rdata, o.extra);
        end
    endtask

    task automatic test_wait_states;
        obs_t o;
        run_txn(1'b0, F3_LHU, 32'h0000_3002, 32'h0, 32'hFFFF_0000, 3, 2, o);
        n_checks++;
        if ({o.reqn, o.cyc} !== {32'd4, 32'd8} || o.stable !== 1'b1) begin
            n_fail++; $display("FAIL wait_timing reqn=%0d cyc=%0d stable=%b want 4 8 1", o.reqn, o.cyc, o.stable);
        end
        n_checks++;
        if ({o.rdata, o.err, o.extra, o.stall_ok} !== {32'h0000_FFFF, 1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL wait_lhu rdata=%h err=%b extra=%b stall_ok=%b want 0000ffff 0 0 1", o.rdata, o.err, o.extra, o.stall_ok);
        end
    endtask

    task automatic test_timeout;
        obs_t o;
        run_txn(1'b0, F3_LW, 32'h0000_4000, 32'h0, 32'h1234_5678, 1000, 0, o);
        n_checks++;
        if ({o.reqn, o.cyc} !== {32'(MW), 32'(MW + 1)}) begin
            n_fail++; $display("FAIL timeout_len reqn=%0d cyc=%0d want %0d %0d", o.reqn, o.cyc, MW, MW + 1);
        end
        n_checks++;
        if ({o.err, o.rdata} !== {1'b1, 32'd0}) begin
            n_fail++; $display("FAIL timeout_err err=%b rdata=%h want 1 0", o.err, o.rdata);
        end
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        n_checks++;
        if ({rsp_valid, mem_req, rsp_rdata} !== 34'd0) begin
            n_fail++; $display("FAIL late_rvalid rsp_valid=%b mem_req=%b rdata=%h want 0 0 0", rsp_valid, mem_req, rsp_rdata);
        end
        run_txn(1'b0, F3_LH, 32'h0000_4002, 32'h0, 32'h8001_7FFF, 1, 1, o);
        n_checks++;
        if ({o.rdata, o.err, o.cyc} !== {32'hFFFF_8001, 1'b0, 32'd5}) begin
            n_fail++; $display("FAIL after_timeout rdata=%h err=%b cyc=%0d want ffff8001 0 5", o.rdata, o.err, o.cyc);
        end
    endtask

    task automatic test_reset_mid;
        obs_t o;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h0000_0040; mem_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        n_checks++;
        if ({stall, mem_req, rsp_valid} !== 3'b100) begin
            n_fail++; $display("FAIL mid_data stall/mem_req/rsp_valid=%b want 100", {stall, mem_req, rsp_valid});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({stall, rsp_valid, rsp_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_rdata} !== '0) begin
            n_fail++; $display("FAIL mid_reset stall=%b rsp_valid=%b mem_req=%b mem_addr=%h want all 0", stall, rsp_valid, mem_req, mem_addr);
        end
        mem_rvalid = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        rst = 1'b1;
        run_txn(1'b0, F3_LW, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 0, 0, o);
        n_checks++;
        if ({o.rdata, o.err, o.cyc, o.addr} !== {32'hCAFE_F00D, 1'b0, 32'd3, 32'h0000_0040}) begin
            n_fail++; $display("FAIL after_reset rdata=%h err=%b cyc=%0d addr=%h want cafef00d 0 3 00000040", o.rdata, o.err, o.cyc, o.addr);
        end
    endtask

    task automatic test_back_to_back;
        obs_t a, b;
        run_txn(1'b0, F3_LBU, 32'h0000_0105, 32'h0, 32'h11FE_3344, 0, 0, a);
        run_txn(1'b1, F3_SB, 32'h0000_0107, 32'h0000_00A5, 32'h0, 0, 0, b);
        n_checks++;
        if ({a.rdata, a.cyc} !== {32'h0000_0033, 32'd3}) begin
            n_fail++; $display("FAIL b2b_first rdata=%h cyc=%0d want 00000033 3", a.rdata, a.cyc);
        end
        n_checks++;
        if ({b.cyc, b.be, b.wdata, b.err} !== {32'd3, 4'b1000, 32'hA5A5_A5A5, 1'b0}) begin
            n_fail++; $display("FAIL b2b_second cyc=%0d be=%b wdata=%h err=%b want 3 1000 a5a5a5a5 0", b.cyc, b.be, b.wdata, b.err);
        end
    endtask

    task automatic test_random;
        obs_t o;
        logic err, we;
        logic [2:0] f3;
        logic [3:0] be;
        logic [31:0] mw, rv, addr, wd, rdw;
        int gd, rd, ecyc;
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
            addr = $urandom; wd = $urandom; rdw = $urandom;
            gd = $urandom_range(0, 2); rd = $urandom_range(0, 2);
            model(we, f3, addr, wd, rdw, err, be, mw, rv);
            run_txn(we, f3, addr, wd, rdw, gd, rd, o);
            ecyc = err ? 1 : 3 + gd + rd;
            n_checks++;
            if (o.cyc !== ecyc || o.reqn !== (err ? 0 : gd + 1)) begin
                n_fail++; $display("FAIL rnd%0d_timing cyc=%0d reqn=%0d want %0d %0d", n, o.cyc, o.reqn, ecyc, err ? 0 : gd + 1);
            end
            n_checks++;
            if ({o.rdata, o.err, o.extra, o.stall_ok} !== {rv, err, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL rnd%0d_rsp rdata=%h err=%b extra=%b stall_ok=%b want %h %b 0 1", n, o.rdata, o.err, o.extra, o.stall_ok, rv, err);
            end
            if (!err) begin
                n_checks++;
                if ({o.addr, o.be, o.we, o.stable} !== {addr[31:2], 2'b00, be, we, 1'b1} || (we && o.wdata !== mw)) begin
                    n_fail++; $display("FAIL rnd%0d_bus addr=%h be=%b we=%b wdata=%h stable=%b want %h %b %b %h 1", n, o.addr, o.be, o.we, o.wdata, o.stable, {addr[31:2], 2'b00}, be, we, mw);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_wait_states();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
